ltc2308_spi_responder: RTL
==========================

// Module: ltc2308_spi_responder
// PURPOSE
// Synthesizable LTC2308 device emulator: the ADC end of the CONVST/SCK/SDI/SDO link that the FIFO ADC controller drives.
// Decodes the 6-bit config word and returns 12-bit samples from an 8-entry channel table, MSB first.
// Sits in the test/loopback fabric in place of the real chip, so capture paths run without analog hardware.
// PARAMETERS
// CONV_CYCLES  64  adc_clk cycles from the CONVST rising edge until the data phase may start (tCONV model)
// SYNC_STAGES  2   flip-flop synchronizer depth on ADC_CONVST, ADC_SCK and ADC_SDI (minimum 2)
// RAMP_STEP    1   per-frame increment, used only with LTC_EMU_RAMP_EN
// PORTS
// adc_clk      in   1   sole clock; must be at least 4x the SCK frequency
// adc_reset_n  in   1   asynchronous active-low reset
// ADC_CONVST   in   1   conversion start from the master
// ADC_SCK      in   1   serial clock from the master
// ADC_SDI      in   1   config bits from the master, MSB first: S/D O/S S1 S0 UNI SLP
// ADC_SDO      out  1   sample bits to the master, MSB first
// tbl_wr_en    in   1   channel table write strobe
// tbl_wr_addr  in   3   channel table write index
// tbl_wr_data  in   12  channel table write value
// cfg_active   out  6   config word in force for the current conversion
// busy         out  1   high while in CONVERT
// frame_done   out  1   one-cycle pulse after the 12th SCK falling edge
// frame_abort  out  1   one-cycle pulse when a CONVST rise cuts a frame short
// protocol_err out  1   sticky; an SCK edge was seen during CONVERT; cleared only by reset
// BEHAVIOUR
// - Reset values: ADC_SDO=0, cfg_active=6'b100010 (CH0, unipolar), busy=0, pulses=0, protocol_err=0, table entries=0, state=IDLE.
// - Edges are detected on the synchronized inputs, so every port response lags its pin by SYNC_STAGES+1 cycles.
// - State IDLE: CONVST rise -> CONVERT.
// - State CONVERT: counter runs 0..CONV_CYCLES-1, then -> WAIT. An SCK edge here sets protocol_err and is otherwise ignored.
// - State WAIT: once CONVST is low, load shreg <= sample(cfg_active) and drive ADC_SDO = shreg[11] in the same cycle; -> SHIFT.
// - State SHIFT:
//   - SCK rising: shift SDI into cfg_sh; bits are counted 0..5.
//   - SCK falling: shreg <= {shreg[10:0],1'b0}; ADC_SDO follows the new MSB.
//   - After the 12th falling edge: ADC_SDO=0, frame_done pulses, -> IDLE.
// - Config latch: cfg_active <= cfg_sh on the cycle after the 6th SCK rise, so the config applies to the NEXT conversion, as on the real part.
// - Sample select: ch = {S1,S0,O/S}.
//   - UNI=1: sample = tbl[ch].
//   - UNI=0: sample = tbl[ch] ^ 12'h800 (offset to two's complement).
//   - S/D=0 (differential) uses the same index; no special handling.
//   - SLP is stored in cfg_active but has no other effect.
// - CONVST rise in SHIFT or WAIT: frame_abort pulses, ADC_SDO=0, -> CONVERT. cfg_sh is discarded if fewer than 6 bits arrived.
// - CONVST rise during CONVERT: ignored, the counter does not restart.
// - Table write on the same cycle as the WAIT load: the load returns the old value; the write lands next cycle.
// - SCK edges in IDLE: ignored, no error.
// - Reset mid-frame: immediate return to all reset values; no pulses are emitted.
// CONFIGURATION
// - LTC_EMU_RAMP_EN defined: on each frame_done, tbl[ch of that frame] <= tbl + RAMP_STEP (mod 4096). A same-cycle tbl_wr_en to that entry wins.
// - LTC_EMU_RAMP_EN undefined: the table changes only through tbl_wr_en; no ramp logic is built.
// TESTING
// - Power-up, write tbl[0]=12'hABC, one frame with SDI=6'b100010 -> SDO shifts 1010_1011_1100, then frame_done=1 for 1 cycle.
// - Frame 1 sends cfg 6'b110010 (CH1), tbl[1]=12'h123 -> frame 1 returns CH0 data; frame 2 returns 12'h123.
// - cfg 6'b100000 (UNI=0, CH0), tbl[0]=12'h005 -> frame 2 returns 12'h805.
// - CONVST pulse after 5 SCK cycles -> frame_abort=1, cfg_active unchanged, next frame completes normally.
// - SCK toggled during CONVERT -> protocol_err=1 and stays set until adc_reset_n is asserted.
// - With LTC_EMU_RAMP_EN and tbl[0]=12'hFFF, two CH0 frames -> returns 12'hFFF, then 12'h000 (wrap).

Source files
------------

// File: rtl/ltc2308_spi_responder.sv
// ---------------------------------------------------------------------------
// ltc2308_spi_responder
//
// Synthesizable LTC2308 device emulator. It is the ADC end of the
// CONVST/SCK/SDI/SDO link that the FIFO ADC controller drives, so capture
// paths can run in the test/loopback fabric without analog hardware.
//
// A CONVST rise starts a modelled conversion of CONV_CYCLES adc_clk cycles.
// The data phase then shifts a 12-bit sample out on ADC_SDO, MSB first.
// The sample is taken from an 8-entry channel table. At the same time the
// 6-bit config word (S/D O/S S1 S0 UNI SLP) is shifted in on ADC_SDI.
// That word takes effect for the NEXT conversion, as on the real part.
//
// Optional feature:
//   LTC_EMU_RAMP_EN : when defined, each completed frame adds RAMP_STEP
//                     (mod 4096) to the table entry it returned.
//
// Parameters:
//   CONV_CYCLES  adc_clk cycles of the CONVERT phase (tCONV model)
//   SYNC_STAGES  synchronizer depth on ADC_CONVST/ADC_SCK/ADC_SDI (>= 2)
//   RAMP_STEP    per-frame increment, used only with LTC_EMU_RAMP_EN
//
// Ports:
//   adc_clk       in   sole clock, at least 4x the SCK frequency
//   adc_reset_n   in   asynchronous active-low reset
//   ADC_CONVST    in   conversion start from the master
//   ADC_SCK       in   serial clock from the master
//   ADC_SDI       in   config bits from the master, MSB first
//   ADC_SDO       out  sample bits to the master, MSB first
//   tbl_wr_en     in   channel table write strobe
//   tbl_wr_addr   in   channel table write index
//   tbl_wr_data   in   channel table write value
//   cfg_active    out  config word in force for the current conversion
//   busy          out  high while in CONVERT
//   frame_done    out  one-cycle pulse after the 12th SCK falling edge
//   frame_abort   out  one-cycle pulse when a CONVST rise cuts a frame short
//   protocol_err  out  sticky: an SCK edge was seen during CONVERT
// ---------------------------------------------------------------------------
module ltc2308_spi_responder #(
    parameter int CONV_CYCLES = 64,
    parameter int SYNC_STAGES = 2,
    parameter int RAMP_STEP   = 1
) (
    input  logic        adc_clk,
    input  logic        adc_reset_n,
    input  logic        ADC_CONVST,
    input  logic        ADC_SCK,
    input  logic        ADC_SDI,
    output logic        ADC_SDO,
    input  logic        tbl_wr_en,
    input  logic [2:0]  tbl_wr_addr,
    input  logic [11:0] tbl_wr_data,
    output logic [5:0]  cfg_active,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_abort,
    output logic        protocol_err
);

    localparam int          CNT_W     = $clog2(CONV_CYCLES + 1);
    localparam logic [5:0]  CFG_RESET = 6'b100010;  // CH0, single-ended, unipolar

    // Elaboration-time parameter sanity checks.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (RAMP_STEP < 0) begin : g_bad_ramp
        $error("RAMP_STEP must not be negative");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_WAIT    = 2'd2,
        ST_SHIFT   = 2'd3
    } state_t;

    state_t state, state_nx;

    // -----------------------------------------------------------------------
    // Input synchronizers and edge detection
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] convst_sync, sck_sync, sdi_sync;
    logic                   convst_d, sck_d;
    logic                   convst_s, sck_s, sdi_s;
    logic                   convst_rise, sck_rise, sck_fall;

    // NOTE: every clocked block uses non-blocking (<=) assignments. All flops
    // then sample pre-edge values, and a synchronizer chain really is
    // SYNC_STAGES deep rather than collapsing into a single wire.
    always_ff @(posedge adc_clk or negedge adc_reset_n) begin
        if (!adc_reset_n) begin
            convst_sync <= '0;
            sck_sync    <= '0;
            sdi_sync    <= '0;
            convst_d    <= 1'b0;
            sck_d       <= 1'b0;
        end else begin
            convst_sync <= {convst_sync[SYNC_STAGES-2:0], ADC_CONVST};
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], ADC_SCK};
            sdi_sync    <= {sdi_sync[SYNC_STAGES-2:0], ADC_SDI};
            convst_d    <= convst_s;
            sck_d       <= sck_s;
        end
    end

    assign convst_s    = convst_sync[SYNC_STAGES-1];
    assign sck_s       = sck_sync[SYNC_STAGES-1];
    // SDI uses the same depth as SCK, so each bit stays aligned with its edge.
    assign sdi_s       = sdi_sync[SYNC_STAGES-1];
    assign convst_rise = convst_s & ~convst_d;
    assign sck_rise    = sck_s & ~sck_d;
    assign sck_fall    = ~sck_s & sck_d;

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] conv_cnt;
    logic [11:0]      shreg;
    logic [5:0]       cfg_sh;
    logic [2:0]       rise_cnt;
    logic [3:0]       fall_cnt;
    logic             cfg_load;

    // Channel table
    logic [11:0]      tbl [8];
    logic [2:0]       ch;
    logic [11:0]      sample;

    // Control strobes from the next-state logic
    logic start_conv, load_sample, shift_out, take_sdi, end_frame, abort, conv_err;

    // ch = {S1, S0, O/S}. S/D does not change the index.
    assign ch     = {cfg_active[3], cfg_active[2], cfg_active[4]};
    // UNI=0 returns the two's-complement view of the stored offset-binary code.
    assign sample = cfg_active[1] ? tbl[ch] : (tbl[ch] ^ 12'h800);
    assign busy   = (state == ST_CONVERT);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge adc_clk or negedge adc_reset_n) begin
        if (!adc_reset_n) state <= ST_IDLE;
        else              state <= state_nx;
    end

    // -----------------------------------------------------------------------
    // FSM: next state and control strobes
    // -----------------------------------------------------------------------
    // NOTE: every output of this block is given a default before the case
    // statement. A path that leaves any of them unassigned would infer a latch.
    always_comb begin
        state_nx    = state;
        start_conv  = 1'b0;
        load_sample = 1'b0;
        shift_out   = 1'b0;
        take_sdi    = 1'b0;
        end_frame   = 1'b0;
        abort       = 1'b0;
        conv_err    = 1'b0;

        case (state)
            ST_IDLE: begin
                // SCK activity here is legal bus idle noise, not an error.
                if (convst_rise) begin
                    start_conv = 1'b1;
                    state_nx   = ST_CONVERT;
                end
            end

            ST_CONVERT: begin
                // A CONVST rise here is ignored, so the counter keeps running.
                conv_err = sck_rise | sck_fall;
                if (conv_cnt == CNT_W'(CONV_CYCLES - 1)) state_nx = ST_WAIT;
            end

            ST_WAIT: begin
                if (convst_rise) begin
                    abort      = 1'b1;
                    start_conv = 1'b1;
                    state_nx   = ST_CONVERT;
                end else if (!convst_s) begin
                    load_sample = 1'b1;
                    state_nx    = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (convst_rise) begin
                    abort      = 1'b1;
                    start_conv = 1'b1;
                    state_nx   = ST_CONVERT;
                end else begin
                    take_sdi = sck_rise && (rise_cnt < 3'd6);
                    if (sck_fall) begin
                        if (fall_cnt == 4'd11) begin
                            end_frame = 1'b1;
                            state_nx  = ST_IDLE;
                        end else begin
                            shift_out = 1'b1;
                        end
                    end
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Conversion timer, shift registers, config latch and status
    // -----------------------------------------------------------------------
    always_ff @(posedge adc_clk or negedge adc_reset_n) begin
        if (!adc_reset_n) begin
            conv_cnt     <= '0;
            shreg        <= '0;
            cfg_sh       <= '0;
            rise_cnt     <= '0;
            fall_cnt     <= '0;
            cfg_load     <= 1'b0;
            cfg_active   <= CFG_RESET;
            ADC_SDO      <= 1'b0;
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            frame_done   <= end_frame;
            frame_abort  <= abort;
            protocol_err <= protocol_err | conv_err;

            if (start_conv)              conv_cnt <= '0;
            else if (state == ST_CONVERT) conv_cnt <= conv_cnt + 1'b1;

            // Config capture: only a complete 6-bit word reaches cfg_active.
            // A partial word is dropped when the next frame resets rise_cnt.
            cfg_load <= take_sdi && (rise_cnt == 3'd5);
            if (start_conv || load_sample) begin
                rise_cnt <= '0;
            end else if (take_sdi) begin
                rise_cnt <= rise_cnt + 1'b1;
                cfg_sh   <= {cfg_sh[4:0], sdi_s};
            end
            if (cfg_load) cfg_active <= cfg_sh;

            // Sample output path: SDO always mirrors the current shreg MSB.
            if (load_sample) begin
                shreg    <= sample;
                fall_cnt <= '0;
                ADC_SDO  <= sample[11];
            end else if (shift_out) begin
                shreg    <= {shreg[10:0], 1'b0};
                fall_cnt <= fall_cnt + 1'b1;
                ADC_SDO  <= shreg[10];
            end else if (abort || end_frame) begin
                ADC_SDO  <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Channel table
    // -----------------------------------------------------------------------
`ifdef LTC_EMU_RAMP_EN
    logic [2:0] frame_ch;

    always_ff @(posedge adc_clk or negedge adc_reset_n) begin
        if (!adc_reset_n)     frame_ch <= '0;
        else if (load_sample) frame_ch <= ch;
    end
`endif

    // NOTE: the table has an explicit reset. After reset the emulator must
    // return all-zero samples, not undefined ones. For that reason the table
    // is built from resettable flops and is never mapped to a RAM macro.
    always_ff @(posedge adc_clk or negedge adc_reset_n) begin
        if (!adc_reset_n) begin
            for (int i = 0; i < 8; i++) tbl[i] <= '0;
        end else begin
`ifdef LTC_EMU_RAMP_EN
            // The ramp advances in the cycle that frame_done is high. A
            // same-cycle write to the entry wins because it is assigned later.
            if (frame_done) tbl[frame_ch] <= tbl[frame_ch] + 12'(RAMP_STEP);
`endif
            // A write in the same cycle as the WAIT load is seen by the next
            // conversion. The load already captured the old value.
            if (tbl_wr_en) tbl[tbl_wr_addr] <= tbl_wr_data;
        end
    end

endmodule
